fmac_iter_normalizer: RTL and testbench
=======================================

// Module: fmac_iter_normalizer
// PURPOSE
// Back end of the fmac datapath: the inverse of pre-add alignment. Takes the unsigned
// post-adder magnitude, its signed biased exponent, sign and incoming sticky. Renormalizes
// with a bounded per-cycle left shift, or a single right shift on overflow, to produce a
// (C_MANT+1)-bit significand plus round/sticky for the rounder. Multi-cycle, valid/ready
// on both sides, one operation in flight.
// PARAMETERS
// C_EXP    8   exponent field width
// C_MANT   23  fraction width (significand = C_MANT+1 bits)
// C_WIDTH  75  adder-result width; bit C_WIDTH-1 = carry headroom, bit C_WIDTH-2 = target MSB
// C_STEP   16  maximum left-shift distance per cycle
// PORTS
// Clk_CI        in   1            clock
// Rst_RBI       in   1            reset, synchronous, active-low
// Valid_SI      in   1            input operand valid
// Ready_SO      out  1            block can accept (1 only in IDLE)
// Mant_DI       in   C_WIDTH      unsigned magnitude; weight of bit C_WIDTH-2 = 2^(Exp_DI-bias)
// Exp_DI        in   C_EXP+2      signed two's-complement biased exponent
// Sign_DI       in   1            result sign, passed through
// Sticky_SI     in   1            sticky from alignment shift-out
// Valid_SO      out  1            result valid (DONE state)
// Ready_SI      in   1            downstream accepts result
// Mant_norm_DO  out  C_MANT+1     normalized significand = reg[C_WIDTH-2 -: C_MANT+1]
// Round_SO      out  1            reg[C_WIDTH-C_MANT-3]
// Sticky_SO     out  1            OR(reg[C_WIDTH-C_MANT-4:0]) | accumulated sticky
// Exp_norm_DO   out  C_EXP+2      final exponent; 0 when Denorm_SO or Zero_SO
// Sign_norm_DO  out  1            registered Sign_DI
// Zero_SO       out  1            magnitude and sticky both zero
// Denorm_SO     out  1            nonzero, bit C_WIDTH-2 still 0 at exponent floor
// BEHAVIOUR
// - Reset (Rst_RBI=0 at posedge): state IDLE; all output registers 0; Valid_SO=0; Ready_SO=1.
//   Reset mid-operation discards the operation, with no output.
// - FSM IDLE -> SHIFT on Valid_SI&Ready_SO: latch mant/exp/sign/sticky.
// - SHIFT: one step per cycle, checked in this order:
//   a. mant==0: Zero; exp:=0; go to DONE.
//   b. Exp<1 on the first SHIFT cycle: right-shift by min(1-Exp, C_WIDTH); exp:=1;
//      OR all shifted-out bits into sticky. Then continue with the rules below on later cycles.
//   c. bit C_WIDTH-1 set: right-shift 1; exp+=1; shifted-out bit ORs into sticky; go to DONE.
//   d. lz = leading zeros from bit C_WIDTH-2. If lz==0 or exp==1, go to DONE. Otherwise
//      left-shift by s=min(lz, C_STEP, exp-1) and set exp-=s. Repeat.
//   Every operation spends at least one SHIFT cycle. Left-shift cycles = ceil(min(lz,exp-1)/C_STEP).
// - DONE: outputs registered and stable while Valid_SO=1 and Ready_SI=0. On Ready_SI, go to IDLE.
//   No same-cycle accept from DONE.
// - Latency: accept at cycle 0; Valid_SO at cycle 1+N, with N the number of SHIFT cycles.
// - Denorm_SO=1 iff result nonzero and bit C_WIDTH-2 is 0 when exp==1; Exp_norm_DO is then 0.
// - Exponent arithmetic is C_EXP+2 bits signed. Overflow above 2^C_EXP-2 is passed
//   unclamped for the rounder to flag.
// - Inputs are ignored outside IDLE. Ready_SI is ignored outside DONE.
// TESTING (C_WIDTH=75, C_STEP=16: Mant_norm=bits73:50, Round=bit49)
// 1 Mant=1<<73, Exp=127, Sticky=0 -> N=1; Mant_norm=0x800000, Exp=127, R=0, S=0, Valid at cycle 2
// 2 Mant=(1<<74)|1, Exp=100 -> N=1; Mant_norm=0x800000, Exp=101, Sticky_SO=1
// 3 Mant=1<<20, Exp=127 -> shifts 16,16,16,5; N=4 (+1 check); Exp=74, Mant_norm=0x800000
// 4 Mant=1<<60, Exp=5 -> shift 4, exp floor 1; Mant_norm=0x004000, Denorm_SO=1, Exp_norm=0
// 5 Mant=0, Sticky=0 -> Zero_SO=1, Exp_norm=0, Mant_norm=0, Valid at cycle 2
// 6 Ready_SI=0 for 5 cycles in DONE -> outputs stable, Ready_SO=0; reset asserted in SHIFT ->
//   next cycle Valid_SO=0, Ready_SO=1, no result emitted

Source files
------------

// File: rtl/fmac_iter_normalizer.sv
// Iterative post-add normalizer for the fmac datapath: renormalizes the adder magnitude
// with bounded left shifts (or one right shift on carry) and hands significand/R/S to the rounder.
module fmac_iter_normalizer #(
  parameter int C_EXP   = 8,
  parameter int C_MANT  = 23,
  parameter int C_WIDTH = 75,
  parameter int C_STEP  = 16
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic                    Valid_SI,
  output logic                    Ready_SO,
  input  logic [C_WIDTH-1:0]      Mant_DI,
  input  logic signed [C_EXP+1:0] Exp_DI,
  input  logic                    Sign_DI,
  input  logic                    Sticky_SI,
  output logic                    Valid_SO,
  input  logic                    Ready_SI,
  output logic [C_MANT:0]         Mant_norm_DO,
  output logic                    Round_SO,
  output logic                    Sticky_SO,
  output logic signed [C_EXP+1:0] Exp_norm_DO,
  output logic                    Sign_norm_DO,
  output logic                    Zero_SO,
  output logic                    Denorm_SO
);

  localparam int EW  = C_EXP + 2;
  localparam int LZW = $clog2(C_WIDTH);
  localparam int RB  = C_WIDTH - C_MANT - 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic signed [EW-1:0] ESTEP = EW'(C_STEP);
  localparam logic signed [EW:0]   RMAX  = (EW+1)'(C_WIDTH);

  logic [1:0]             r_state;
  logic                   r_first;
  logic [C_WIDTH-1:0]     r_mant;
  logic signed [EW-1:0]   r_exp;
  logic                   r_sign;
  logic                   r_sticky;
  logic                   r_zero;
  logic                   r_denorm;

  logic [LZW-1:0]         w_lz;
  logic signed [EW-1:0]   w_lz_e;
  logic signed [EW-1:0]   w_em1;
  logic signed [EW-1:0]   w_step;
  logic signed [EW:0]     w_rdist;
  logic [EW:0]            w_rsh;
  logic [C_WIDTH-1:0]     w_rmask;

  // Leading zeros counted from the target MSB (bit C_WIDTH-2) downwards.
  function automatic logic [LZW-1:0] f_lzc(input logic [C_WIDTH-2:0] m);
    f_lzc = LZW'(C_WIDTH - 1);
    for (int i = 0; i < C_WIDTH - 1; i++) begin
      if (m[i]) f_lzc = LZW'(C_WIDTH - 2 - i);
    end
  endfunction

  always_comb begin
    w_lz   = f_lzc(r_mant[C_WIDTH-2:0]);
    w_lz_e = EW'(w_lz);
    w_em1  = r_exp - EONE;
    w_step = w_lz_e;
    if (w_step > ESTEP) w_step = ESTEP;
    if (w_step > w_em1) w_step = w_em1;
    // Denormal pre-shift distance, saturated so everything can fall into sticky.
    w_rdist = (EW+1)'(1) - (EW+1)'(r_exp);
    w_rsh   = (w_rdist > RMAX) ? RMAX : w_rdist;
    w_rmask = ~({C_WIDTH{1'b1}} << w_rsh);
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      r_state  <= S_IDLE;
      r_first  <= 1'b0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
      r_denorm <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Valid_SI) begin
            r_mant   <= Mant_DI;
            r_exp    <= Exp_DI;
            r_sign   <= Sign_DI;
            r_sticky <= Sticky_SI;
            r_first  <= 1'b1;
            r_zero   <= 1'b0;
            r_denorm <= 1'b0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_first <= 1'b0;
          if (r_mant == '0) begin
            r_zero  <= ~r_sticky;
            r_exp   <= '0;
            r_state <= S_DONE;
          end else if (r_first && (r_exp < EONE)) begin
            r_mant   <= r_mant >> w_rsh;
            r_sticky <= r_sticky | (|(r_mant & w_rmask));
            r_exp    <= EONE;
          end else if (r_mant[C_WIDTH-1]) begin
            r_mant   <= r_mant >> 1;
            r_exp    <= r_exp + EONE;
            r_sticky <= r_sticky | r_mant[0];
            r_state  <= S_DONE;
          end else if ((w_lz == '0) || (r_exp == EONE)) begin
            r_state <= S_DONE;
            if (!r_mant[C_WIDTH-2]) begin
              r_denorm <= 1'b1;
              r_exp    <= '0;
            end
          end else begin
            r_mant <= r_mant << w_step;
            r_exp  <= r_exp - w_step;
          end
        end
        S_DONE: begin
          if (Ready_SI) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Ready_SO     = (r_state == S_IDLE);
  assign Valid_SO     = (r_state == S_DONE);
  assign Mant_norm_DO = r_mant[C_WIDTH-2 -: C_MANT+1];
  assign Round_SO     = r_mant[RB];
  assign Sticky_SO    = r_sticky | (|r_mant[RB-1:0]);
  assign Exp_norm_DO  = r_exp;
  assign Sign_norm_DO = r_sign;
  assign Zero_SO      = r_zero;
  assign Denorm_SO    = r_denorm;

endmodule

// File: tb/tb_fmac_iter_normalizer.sv
// Directed-vector bench for fmac_iter_normalizer with hand-computed expectations.
module tb_fmac_iter_normalizer;

  logic          Clk_CI = 1'b0;
  logic          Rst_RBI = 1'b0;
  logic          Valid_SI = 1'b0;
  logic          Ready_SO;
  logic [74:0]   Mant_DI = '0;
  logic [9:0]    Exp_DI = '0;
  logic          Sign_DI = 1'b0;
  logic          Sticky_SI = 1'b0;
  logic          Valid_SO;
  logic          Ready_SI = 1'b0;
  logic [23:0]   Mant_norm_DO;
  logic          Round_SO;
  logic          Sticky_SO;
  logic [9:0]    Exp_norm_DO;
  logic          Sign_norm_DO;
  logic          Zero_SO;
  logic          Denorm_SO;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk_CI = ~Clk_CI;

  fmac_iter_normalizer #(
    .C_EXP(8), .C_MANT(23), .C_WIDTH(75), .C_STEP(16)
  ) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .Valid_SI(Valid_SI), .Ready_SO(Ready_SO),
    .Mant_DI(Mant_DI), .Exp_DI(Exp_DI), .Sign_DI(Sign_DI), .Sticky_SI(Sticky_SI),
    .Valid_SO(Valid_SO), .Ready_SI(Ready_SI),
    .Mant_norm_DO(Mant_norm_DO), .Round_SO(Round_SO), .Sticky_SO(Sticky_SO),
    .Exp_norm_DO(Exp_norm_DO), .Sign_norm_DO(Sign_norm_DO),
    .Zero_SO(Zero_SO), .Denorm_SO(Denorm_SO)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic launch(input logic [74:0] m, input int e, input logic st, input logic sg);
    @(posedge Clk_CI); #1;
    Mant_DI = m; Exp_DI = 10'(e); Sticky_SI = st; Sign_DI = sg; Valid_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Valid_SI = 1'b0; Mant_DI = '1; Exp_DI = 10'd3; Sticky_SI = 1'b1; Sign_DI = ~sg;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!Valid_SO && cyc < 100) begin
      @(posedge Clk_CI); #1;
      cyc++;
    end
  endtask

  task automatic run_case(input string tag, input logic [74:0] m, input int e,
                          input logic st, input logic sg, input int lat,
                          input logic [23:0] mn, input int ee,
                          input logic r, input logic s, input logic z, input logic d);
    int cyc;
    launch(m, e, st, sg);
    wait_valid(cyc);
    check({tag, ".lat"},    80'(cyc), 80'(lat));
    check({tag, ".mant"},   80'(Mant_norm_DO), 80'(mn));
    check({tag, ".exp"},    80'(Exp_norm_DO), 80'(10'(ee)));
    check({tag, ".round"},  80'(Round_SO), 80'(r));
    check({tag, ".sticky"}, 80'(Sticky_SO), 80'(s));
    check({tag, ".zero"},   80'(Zero_SO), 80'(z));
    check({tag, ".denorm"}, 80'(Denorm_SO), 80'(d));
    check({tag, ".sign"},   80'(Sign_norm_DO), 80'(sg));
    Ready_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Ready_SI = 1'b0;
    check({tag, ".release"}, 80'({Ready_SO, Valid_SO}), 80'(2'b10));
  endtask

  initial begin
    int  cyc;
    logic seen;

    repeat (2) @(posedge Clk_CI);
    #1;
    check("rst.ready", 80'(Ready_SO), 80'(1));
    check("rst.valid", 80'(Valid_SO), 80'(0));
    check("rst.mant",  80'(Mant_norm_DO), 80'(0));
    check("rst.exp",   80'(Exp_norm_DO), 80'(0));
    check("rst.zero",  80'(Zero_SO), 80'(0));
    Rst_RBI = 1'b1;

    //        tag    mantissa                      exp  st  sg  lat mant_norm   exp R  S  Z  D
    run_case("t1",  75'd1 << 73,                  127, 0, 0, 2, 24'h800000, 127, 0, 0, 0, 0);
    run_case("t2",  (75'd1 << 74) | 75'd1,         100, 0, 1, 2, 24'h800000, 101, 0, 1, 0, 0);
    run_case("t3",  75'd1 << 20,                   127, 0, 0, 6, 24'h800000,  74, 0, 0, 0, 0);
    run_case("t4",  75'd1 << 60,                     5, 0, 0, 3, 24'h004000,   0, 0, 0, 0, 1);
    run_case("t5",  75'd0,                          50, 0, 0, 2, 24'h000000,   0, 0, 0, 1, 0);
    run_case("t6",  75'd1 << 73,                    -2, 0, 1, 3, 24'h100000,   0, 0, 0, 0, 1);
    run_case("t7",  (75'd1 << 73) | 75'd1,           0, 0, 0, 3, 24'h400000,   0, 0, 1, 0, 1);
    run_case("t8",  (75'd1 << 73) | (75'd1 << 49),  10, 0, 0, 2, 24'h800000,  10, 1, 0, 0, 0);
    run_case("t9",  (75'd1 << 73) | (75'd1 << 48),  10, 0, 0, 2, 24'h800000,  10, 0, 1, 0, 0);
    run_case("t10", 75'd1 << 73,                  -200, 0, 0, 3, 24'h000000,   0, 0, 1, 0, 0);
    run_case("t11", 75'd1 << 74,                   255, 0, 0, 2, 24'h800000, 256, 0, 0, 0, 0);
    run_case("t12", 75'd0,                          20, 1, 0, 2, 24'h000000,   0, 0, 1, 0, 0);
    run_case("t13", 75'd1 << 73,                     3, 1, 1, 2, 24'h800000,   3, 0, 1, 0, 0);
    run_case("t14", 75'd1 << 72,                     1, 0, 0, 2, 24'h400000,   0, 0, 0, 0, 1);
    run_case("t15", 75'd1 << 57,                   100, 0, 0, 3, 24'h800000,  84, 0, 0, 0, 0);

    // Backpressure: result must hold while Ready_SI stays low, new inputs ignored.
    launch(75'd1 << 20, 127, 0, 1);
    wait_valid(cyc);
    check("hold.lat", 80'(cyc), 80'(6));
    Valid_SI = 1'b1; Mant_DI = 75'd1 << 74; Exp_DI = 10'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk_CI); #1;
      check("hold.valid", 80'(Valid_SO), 80'(1));
      check("hold.ready", 80'(Ready_SO), 80'(0));
      check("hold.mant",  80'(Mant_norm_DO), 80'(24'h800000));
      check("hold.exp",   80'(Exp_norm_DO), 80'(74));
      check("hold.sign",  80'(Sign_norm_DO), 80'(1));
    end
    Valid_SI = 1'b0;
    Ready_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Ready_SI = 1'b0;
    check("hold.release", 80'({Ready_SO, Valid_SO}), 80'(2'b10));

    // Reset while in SHIFT discards the operation.
    launch(75'd1 << 20, 127, 1, 1);
    @(posedge Clk_CI); #1;
    Rst_RBI = 1'b0;
    @(posedge Clk_CI); #1;
    Rst_RBI = 1'b1;
    check("rstmid.valid",  80'(Valid_SO), 80'(0));
    check("rstmid.ready",  80'(Ready_SO), 80'(1));
    check("rstmid.mant",   80'(Mant_norm_DO), 80'(0));
    check("rstmid.exp",    80'(Exp_norm_DO), 80'(0));
    check("rstmid.sticky", 80'(Sticky_SO), 80'(0));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk_CI); #1;
      seen = seen | Valid_SO;
    end
    check("rstmid.noresult", 80'(seen), 80'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
